inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, instruction-memory address width.
REQ-002 SHALL have parameter INST_W, default 19, instruction width; fixed at 19 for the 3-byte packing below.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port loadStart  input  1  request to begin a program load.
REQ-006 SHALL have port byteValid  input  1  source has a byte on byteData.
REQ-007 SHALL have port byteData  input  8  program stream byte.
REQ-008 SHALL have port byteReady  output  1  loader accepts byteData this cycle.
REQ-009 SHALL have port writeEn  output  1  instruction-memory write strobe.
REQ-010 SHALL have port writeAdr  output  ADDR_W  instruction-memory write address.
REQ-011 SHALL have port writeData  output  INST_W  instruction to write.
REQ-012 SHALL have port busy  output  1  load in progress; core held off.
REQ-013 SHALL have port done  output  1  last load completed without error.
REQ-014 SHALL have port error  output  1  last load aborted on a malformed byte.
REQ-015 SHALL have port start  output  1  one-cycle pulse to the controller start input on successful completion.

Function
REQ-016 Byte transfer SHALL occur only on a cycle with byteValid=1 and byteReady=1; byteData is ignored otherwise.
REQ-017 Stream format SHALL be: count low byte, count high byte (bits [3:0] used, [7:4] ignored), then per instruction byte0=inst[7:0], byte1=inst[15:8], byte2=inst[18:16] in [2:0].
REQ-018 States SHALL be IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, DONE, ERR.
REQ-019 IDLE/DONE/ERR: loadStart=1 -> LEN_LO next cycle; clears done and error; address counter cleared to 0.
REQ-020 LEN_LO -> LEN_HI on transfer; LEN_HI -> B0 on transfer if 12-bit count nonzero, else -> DONE.
REQ-021 B0 -> B1 -> B2 each on one transfer; a state with no transfer holds.
REQ-022 B2 transfer with byteData[7:3] != 0 SHALL go to ERR, with no memory write for that instruction.
REQ-023 B2 valid transfer -> WRITE; WRITE lasts exactly one cycle with writeEn=1, writeAdr=address counter, writeData={b2[2:0],b1,b0}.
REQ-024 After WRITE the counter SHALL increment by 1; if the count of written instructions equals the count -> DONE, else -> B0.
REQ-025 byteReady SHALL be 1 exactly in LEN_LO, LEN_HI, B0, B1, B2; 0 in all other states (combinational from state).
REQ-026 busy SHALL be 1 in LEN_LO through WRITE; done=1 only in DONE; error=1 only in ERR.
REQ-027 start SHALL pulse high for exactly the first cycle in DONE, including the zero-count path; never on entry to ERR.
REQ-028 loadStart while busy SHALL be ignored.
REQ-029 Maximum count SHALL be 4095; the counter never wraps within a load; writes cover addresses 0..count-1 in order.
REQ-030 writeAdr and writeData SHALL be don't-care when writeEn=0, but SHALL be registered, with no combinational path from byteData.
REQ-031 Minimum load time SHALL be 2 + 4*count cycles from LEN_LO entry to DONE entry with byteValid held 1.

Reset
REQ-032 rst=1 SHALL force IDLE and byteReady=0, writeEn=0, writeAdr=0, writeData=0, busy=0, done=0, error=0, start=0 on the next edge, from any state.
REQ-033 Reset mid-load SHALL abandon the load with no further writes; the partially written memory is not restored.

Verification
REQ-034 Count=2, bytes 34 12 01 / FF FF 07, byteValid held -> writes (0,0x11234), (1,0x7FFFF); done=1; start one pulse 10 cycles after LEN_LO entry.
REQ-035 Count=0 -> no writeEn; DONE entered after 2 transfers; start pulses once.
REQ-036 Count=1, byte2=0x08 -> ERR; error=1, done=0, no writeEn, no start pulse.
REQ-037 byteValid toggled 1/0 each cycle during count=3 load -> identical writes to the back-to-back case; each byte consumed exactly once.
REQ-038 rst asserted in B1 of instruction 2 -> IDLE next cycle, only address 0 written; a following loadStart restarts at address 0.
REQ-039 loadStart pulsed in B0 -> ignored; the load completes normally.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, packing three
// bytes per 19-bit instruction and signalling the controller when complete.
module inst_mem_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned INST_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadStart,
  input  logic              byteValid,
  input  logic [7:0]        byteData,
  output logic              byteReady,
  output logic              writeEn,
  output logic [ADDR_W-1:0] writeAdr,
  output logic [INST_W-1:0] writeData,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              start
);

  localparam int unsigned CNT_W = 12;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_LO = 4'd1;
  localparam logic [3:0] S_LEN_HI = 4'd2;
  localparam logic [3:0] S_B0     = 4'd3;
  localparam logic [3:0] S_B1     = 4'd4;
  localparam logic [3:0] S_B2     = 4'd5;
  localparam logic [3:0] S_WRITE  = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [7:0]        b0_q, b0_d;
  logic [7:0]        b1_q, b1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              xfer_c;
  logic [CNT_W-1:0]  len_c;

  // Ready is a pure state decode so the source never sees a path from byteData
  assign byteReady = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
  assign xfer_c    = byteValid && byteReady;
  assign len_c     = {byteData[3:0], len_lo_q};

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      rem_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      start_q  <= start_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (loadStart) begin
          state_d = S_LEN_LO;
          addr_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          len_lo_d = byteData;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          rem_d   = len_c;
          state_d = (len_c == '0) ? S_DONE : S_B0;
        end
      end
      S_B0: begin
        if (xfer_c) begin
          b0_d    = byteData;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (xfer_c) begin
          b1_d    = byteData;
          state_d = S_B2;
        end
      end
      S_B2: begin
        // Upper five bits of the last byte must be zero or the stream is malformed
        if (xfer_c) begin
          if (byteData[7:3] != 5'd0) begin
            state_d = S_ERR;
          end else begin
            wdata_d = INST_W'({byteData[2:0], b1_q, b0_q});
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_B0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Start fires only on the edge into DONE, never while lingering there
  assign start_d = (state_d == S_DONE) && (state_q != S_DONE);

  assign writeEn   = (state_q == S_WRITE);
  assign writeAdr  = addr_q;
  assign writeData = wdata_q;
  assign busy      = byteReady || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign start     = start_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized bench: byte streams are decoded by a stream-level reference model
// and the observed memory writes, status and start pulses are compared to it.
module tb_inst_mem_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned INST_W = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic              loadStart;
  logic              byteValid;
  logic [7:0]        byteData;
  logic              byteReady;
  logic              writeEn;
  logic [ADDR_W-1:0] writeAdr;
  logic [INST_W-1:0] writeData;
  logic              busy;
  logic              done;
  logic              error;
  logic              start;

  inst_mem_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .loadStart(loadStart), .byteValid(byteValid),
    .byteData(byteData), .byteReady(byteReady), .writeEn(writeEn),
    .writeAdr(writeAdr), .writeData(writeData), .busy(busy), .done(done),
    .error(error), .start(start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int lenlo_cyc = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe DUT outputs on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (writeEn) got_q.push_back({1'b0, writeAdr, writeData});
    if (start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc + 1;
    end
    if (busy && !busy_prev) lenlo_cyc <= cyc + 1;
    busy_prev <= busy;
  end

  // Reference model: decode the whole stream; writes whose last byte precedes cut_idx
  task automatic model(input int cut_idx, output bit exp_err, output int exp_used, output int exp_cnt);
    int cnt;
    logic [7:0] b0, b1, b2;
    exp_q.delete();
    exp_err  = 1'b0;
    cnt      = 256 * int'(stim_q[1] & 8'h0f) + int'(stim_q[0]);
    exp_cnt  = cnt;
    exp_used = 2;
    for (int i = 0; i < cnt; i++) begin
      b0 = stim_q[2 + 3*i];
      b1 = stim_q[3 + 3*i];
      b2 = stim_q[4 + 3*i];
      exp_used += 3;
      if (b2 > 8'd7) begin
        exp_err = 1'b1;
        break;
      end
      if (cut_idx < 0 || exp_used <= cut_idx)
        exp_q.push_back(32'(i) * 32'h80000 + 32'(b2) * 32'h10000 + 32'(b1) * 32'h100 + 32'(b0));
    end
  endtask

  task automatic build_stream(input int cnt, input bit allow_bad);
    logic [7:0] hi;
    stim_q.delete();
    hi = 8'($urandom_range(0, 15)) << 4;
    stim_q.push_back(8'(cnt % 256));
    stim_q.push_back(hi | 8'(cnt / 256));
    for (int i = 0; i < cnt; i++) begin
      stim_q.push_back(8'($urandom));
      stim_q.push_back(8'($urandom));
      if (allow_bad && $urandom_range(0, 5) == 0) stim_q.push_back(8'($urandom_range(8, 255)));
      else stim_q.push_back(8'($urandom_range(0, 7)));
    end
  endtask

  // mode: 0 valid held, 1 toggling, 2 random. ls_idx/rst_idx: inject at that byte index
  task automatic run_load(input string name, input int mode, input int ls_idx, input int rst_idx);
    bit exp_err;
    int exp_used, exp_cnt, idx, wbase, sbase, limit;
    bit finished, ls_done, v;
    model(rst_idx, exp_err, exp_used, exp_cnt);
    wbase    = got_q.size();
    sbase    = start_cnt;
    idx      = 0;
    finished = 1'b0;
    ls_done  = 1'b0;
    limit    = 8 * stim_q.size() + 50;
    @(negedge clk);
    loadStart = 1'b1;
    byteValid = 1'b0;
    @(negedge clk);
    loadStart = 1'b0;
    for (int t = 0; t < limit; t++) begin
      if (done || error) begin
        finished = 1'b1;
        break;
      end
      if (rst_idx >= 0 && idx == rst_idx && byteReady) begin
        rst = 1'b1;
        byteValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_rst_ctl"}, 32'({byteReady, writeEn, busy, done, error, start}), 32'd0);
        check({name, "_rst_adr"}, 32'(writeAdr), 32'd0);
        check({name, "_rst_dat"}, 32'(writeData), 32'd0);
        finished = 1'b1;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = t[0] == 1'b0;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      byteValid = v;
      byteData  = (v && idx < stim_q.size()) ? stim_q[idx] : 8'($urandom);
      if (!ls_done && idx == ls_idx && byteReady) begin
        loadStart = 1'b1;
        ls_done   = 1'b1;
      end
      #1;
      if (byteValid && byteReady) idx++;
      @(negedge clk);
      loadStart = 1'b0;
    end
    byteValid = 1'b0;
    check({name, "_timeout"}, 32'(finished), 32'd1);
    repeat (3) @(negedge clk);
    if (rst_idx < 0) begin
      check({name, "_done"}, 32'(done), 32'(!exp_err));
      check({name, "_error"}, 32'(error), 32'(exp_err));
      check({name, "_used"}, 32'(idx), 32'(exp_used));
      check({name, "_starts"}, 32'(start_cnt - sbase), 32'(!exp_err));
      if (mode == 0 && !exp_err)
        check({name, "_latency"}, 32'(start_cyc - lenlo_cyc), 32'(2 + 4 * exp_cnt));
    end else begin
      check({name, "_starts"}, 32'(start_cnt - sbase), 32'd0);
    end
    check({name, "_nwr"}, 32'(got_q.size() - wbase), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && wbase + i < got_q.size(); i++)
      check({name, "_wr"}, got_q[wbase + i], exp_q[i]);
  endtask

  initial begin
    rst       = 1'b1;
    loadStart = 1'b0;
    byteValid = 1'b0;
    byteData  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ctl", 32'({byteReady, writeEn, busy, done, error, start}), 32'd0);
    check("reset_adr", 32'(writeAdr), 32'd0);
    check("reset_dat", 32'(writeData), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: count 2, known bytes
    stim_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h07};
    run_load("cnt2", 0, -1, -1);
    check("cnt2_wr0", got_q[got_q.size()-2], {1'b0, 12'd0, 19'h11234});
    check("cnt2_wr1", got_q[got_q.size()-1], {1'b0, 12'd1, 19'h7FFFF});

    // Count zero, with junk in the ignored high nibble
    stim_q = '{8'h00, 8'hF0};
    run_load("cnt0", 0, -1, -1);

    // Malformed last byte
    stim_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h08};
    run_load("bad_b2", 0, -1, -1);

    // Toggled valid on count 3
    build_stream(3, 1'b0);
    run_load("toggle3", 1, -1, -1);

    // Reset in B1 of the second instruction, then reload from address 0
    build_stream(3, 1'b0);
    run_load("rstmid", 0, -1, 6);
    build_stream(1, 1'b0);
    run_load("after_rst", 0, -1, -1);

    // loadStart pulsed in B0 must be ignored
    build_stream(3, 1'b0);
    run_load("ls_in_b0", 0, 2, -1);

    // Random loads
    for (int k = 0; k < 20; k++) begin
      build_stream($urandom_range(0, 8), 1'b1);
      run_load($sformatf("rnd%0d", k), $urandom_range(0, 2), -1, -1);
    end

    // Maximum count
    build_stream(4095, 1'b0);
    run_load("max", 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
